// File: rtl/id_stage.sv
// rtl/id_stage.sv - decode stage: IF/ID latch, 8x16 register file with write bypass,
// load-use stall detection and registered ID/EX outputs.
module id_stage #(
   parameter logic [15:0] NOP_INSTR = 16'h0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] instr_if,
   input  logic [15:0] pc_next_if,
   input  logic        flush,
   input  logic        ex_mem_read,
   input  logic [2:0]  ex_rd,
   input  logic        wb_we,
   input  logic [2:0]  wb_addr,
   input  logic [15:0] wb_data,
   output logic        pc_we,
   output logic        id_valid,
   output logic [3:0]  id_opcode,
   output logic [2:0]  id_rd,
   output logic [2:0]  id_funct,
   output logic [15:0] id_rs_data,
   output logic [15:0] id_rt_data,
   output logic [15:0] id_imm,
   output logic [15:0] id_pc_next
);

   logic [15:0] ifid_instr;
   logic [15:0] ifid_pc_next;
   logic        ifid_valid;

   logic [15:0] regs [0:7];

   logic [3:0]  opcode;
   logic [2:0]  rd;
   logic [2:0]  rs;
   logic [2:0]  rt;
   logic [2:0]  funct;
   logic [5:0]  imm6;

   logic        uses_rs;
   logic        uses_rt;
   logic        stall;
   logic        wb_active;
   logic [15:0] rs_data;
   logic [15:0] rt_data;

   assign opcode = ifid_instr[15:12];
   assign rd     = ifid_instr[11:9];
   assign rs     = ifid_instr[8:6];
   assign rt     = ifid_instr[5:3];
   assign funct  = ifid_instr[2:0];
   assign imm6   = ifid_instr[5:0];

   // R-type (opcode 0) reads rs and rt, I-type (1-7) reads rs only, 8-15 read nothing.
   assign uses_rs = (opcode[3] == 1'b0);
   assign uses_rt = (opcode == 4'd0);

   // A load in EX whose result the instruction in ID needs cannot be forwarded in time.
   assign stall = ex_mem_read && ifid_valid && (ex_rd != 3'd0) &&
                  ((uses_rs && (ex_rd == rs)) || (uses_rt && (ex_rd == rt)));

   assign pc_we = ~stall | flush;

   assign wb_active = wb_we && (wb_addr != 3'd0);

   always_comb begin
      rs_data = '0;
      if (rs != 3'd0) begin
         if (wb_active && (wb_addr == rs)) begin
            rs_data = wb_data;
         end else begin
            rs_data = regs[rs];
         end
      end
   end

   always_comb begin
      rt_data = '0;
      if (rt != 3'd0) begin
         if (wb_active && (wb_addr == rt)) begin
            rt_data = wb_data;
         end else begin
            rt_data = regs[rt];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 8; i++) begin
            regs[i] <= '0;
         end
      end else if (wb_active) begin
         regs[wb_addr] <= wb_data;
      end
   end

   // Flush wins over stall; a stall simply holds the latch.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ifid_instr   <= NOP_INSTR;
         ifid_pc_next <= '0;
         ifid_valid   <= 1'b0;
      end else if (flush) begin
         ifid_instr   <= NOP_INSTR;
         ifid_pc_next <= '0;
         ifid_valid   <= 1'b0;
      end else if (pc_we) begin
         ifid_instr   <= instr_if;
         ifid_pc_next <= pc_next_if;
         ifid_valid   <= 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         id_valid   <= 1'b0;
         id_opcode  <= '0;
         id_rd      <= '0;
         id_funct   <= '0;
         id_rs_data <= '0;
         id_rt_data <= '0;
         id_imm     <= '0;
         id_pc_next <= '0;
      end else if (flush || stall) begin
         id_valid   <= 1'b0;
         id_opcode  <= '0;
         id_rd      <= '0;
         id_funct   <= '0;
         id_rs_data <= '0;
         id_rt_data <= '0;
         id_imm     <= '0;
         id_pc_next <= '0;
      end else begin
         id_valid   <= ifid_valid;
         id_opcode  <= opcode;
         id_rd      <= rd;
         id_funct   <= funct;
         id_rs_data <= rs_data;
         id_rt_data <= rt_data;
         id_imm     <= {{10{imm6[5]}}, imm6};
         id_pc_next <= ifid_pc_next;
      end
   end

endmodule

// File: tb/tb_id_stage.sv
// tb/tb_id_stage.sv - self-checking bench for id_stage against a behavioural decode model.
module tb_id_stage;

   logic        clk;
   logic        rst;
   logic [15:0] instr_if;
   logic [15:0] pc_next_if;
   logic        flush;
   logic        ex_mem_read;
   logic [2:0]  ex_rd;
   logic        wb_we;
   logic [2:0]  wb_addr;
   logic [15:0] wb_data;
   logic        pc_we;
   logic        id_valid;
   logic [3:0]  id_opcode;
   logic [2:0]  id_rd;
   logic [2:0]  id_funct;
   logic [15:0] id_rs_data;
   logic [15:0] id_rt_data;
   logic [15:0] id_imm;
   logic [15:0] id_pc_next;

   int errors = 0;
   int checks = 0;

   id_stage #(.NOP_INSTR(16'h0000)) dut (
      .clk(clk), .rst(rst), .instr_if(instr_if), .pc_next_if(pc_next_if),
      .flush(flush), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
      .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .pc_we(pc_we),
      .id_valid(id_valid), .id_opcode(id_opcode), .id_rd(id_rd), .id_funct(id_funct),
      .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
      .id_pc_next(id_pc_next)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: architectural register array plus the instruction waiting in decode.
   logic [15:0] m_rf [0:7];
   logic [15:0] m_instr;
   logic [15:0] m_pc;
   logic        m_valid;
   logic [74:0] e_vec;
   logic [74:0] dut_vec;
   logic        m_stall;
   logic        exp_pc_we;

   assign dut_vec = {id_valid, id_opcode, id_rd, id_funct, id_rs_data, id_rt_data, id_imm, id_pc_next};

   function automatic logic [15:0] m_read(input logic [2:0] a);
      if (a == 0) return 16'h0000;
      if (wb_we && wb_addr == a) return wb_data;
      return m_rf[a];
   endfunction

   function automatic logic m_needs(input logic [15:0] ins, input logic [2:0] r);
      int op;
      op = int'(ins[15:12]);
      if (op == 0) return (ins[8:6] == r) || (ins[5:3] == r);
      if (op <= 7) return ins[8:6] == r;
      return 1'b0;
   endfunction

   assign m_stall   = ex_mem_read && m_valid && ex_rd != 0 && m_needs(m_instr, ex_rd);
   assign exp_pc_we = !m_stall || flush;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_instr <= 16'h0000;
         m_pc    <= 16'h0000;
         m_valid <= 1'b0;
         e_vec   <= '0;
         for (int i = 0; i < 8; i++) m_rf[i] <= 16'h0000;
      end else begin
         if (flush || m_stall) e_vec <= '0;
         else e_vec <= {m_valid, m_instr[15:12], m_instr[11:9], m_instr[2:0],
                        m_read(m_instr[8:6]), m_read(m_instr[5:3]),
                        16'($signed(m_instr[5:0])), m_pc};
         if (flush) begin
            m_instr <= 16'h0000;
            m_pc    <= 16'h0000;
            m_valid <= 1'b0;
         end else if (!m_stall) begin
            m_instr <= instr_if;
            m_pc    <= pc_next_if;
            m_valid <= 1'b1;
         end
         if (wb_we && wb_addr != 0) m_rf[wb_addr] <= wb_data;
      end
   end

   task automatic idle_inputs();
      instr_if = 16'h8000; pc_next_if = 16'h0000; flush = 0;
      ex_mem_read = 0; ex_rd = 0; wb_we = 0; wb_addr = 0; wb_data = 0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle_inputs();
      #2;
      checks++; if (dut_vec !== 75'd0) begin errors++; $display("FAIL reset_outputs got=%h exp=0", dut_vec); end
      checks++; if (pc_we !== 1'b1) begin errors++; $display("FAIL reset_pc_we got=%b exp=1", pc_we); end
      @(negedge clk); @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
      checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL post_reset_valid got=%b exp=0", id_valid); end
   endtask

   task automatic test_rtype();
      @(negedge clk); wb_we = 1; wb_addr = 2; wb_data = 16'd5;
      @(negedge clk); wb_addr = 3; wb_data = 16'd7;
      @(negedge clk); wb_we = 0; instr_if = 16'h0299; pc_next_if = 16'h0011;
      @(negedge clk); instr_if = 16'h8000;
      @(posedge clk); #1;
      checks++;
      if ({id_valid, id_rd, id_rs_data, id_rt_data, id_pc_next} !== {1'b1, 3'd1, 16'd5, 16'd7, 16'h0011}) begin
         errors++; $display("FAIL rtype got v=%b rd=%0d rs=%h rt=%h pc=%h exp v=1 rd=1 rs=5 rt=7 pc=0011",
                            id_valid, id_rd, id_rs_data, id_rt_data, id_pc_next);
      end
      checks++; if (dut_vec !== e_vec) begin errors++; $display("FAIL rtype_model got=%h exp=%h", dut_vec, e_vec); end
   endtask

   task automatic test_imm();
      @(negedge clk); instr_if = 16'h103E;
      @(negedge clk); instr_if = 16'h101F;
      @(posedge clk); #1;
      checks++; if (id_imm !== 16'hFFFE) begin errors++; $display("FAIL imm_neg got=%h exp=FFFE", id_imm); end
      @(negedge clk); instr_if = 16'h8000;
      @(posedge clk); #1;
      checks++; if (id_imm !== 16'h001F) begin errors++; $display("FAIL imm_pos got=%h exp=001F", id_imm); end
   endtask

   task automatic test_stall();
      @(negedge clk); instr_if = 16'h1A83; pc_next_if = 16'h0040;
      @(negedge clk); ex_mem_read = 1; ex_rd = 2; instr_if = 16'h2E00; pc_next_if = 16'h0041;
      #1;
      checks++; if (pc_we !== 1'b0) begin errors++; $display("FAIL stall_pc_we got=%b exp=0", pc_we); end
      @(posedge clk); #1;
      checks++; if (dut_vec !== 75'd0) begin errors++; $display("FAIL stall_bubble got=%h exp=0", dut_vec); end
      @(negedge clk); ex_mem_read = 0; ex_rd = 0;
      #1;
      checks++; if (pc_we !== 1'b1) begin errors++; $display("FAIL stall_release got=%b exp=1", pc_we); end
      @(posedge clk); #1;
      checks++;
      if ({id_valid, id_rd, id_pc_next} !== {1'b1, 3'd5, 16'h0040}) begin
         errors++; $display("FAIL stall_issue got v=%b rd=%0d pc=%h exp v=1 rd=5 pc=0040", id_valid, id_rd, id_pc_next);
      end
   endtask

   task automatic test_no_stall();
      @(negedge clk); instr_if = 16'h1A83; pc_next_if = 16'h0050;
      @(negedge clk); ex_mem_read = 1; ex_rd = 0; instr_if = 16'h8080;
      #1;
      checks++; if (pc_we !== 1'b1) begin errors++; $display("FAIL no_stall_rd0 got=%b exp=1", pc_we); end
      @(negedge clk); ex_rd = 2; instr_if = 16'h8000;
      #1;
      checks++; if (pc_we !== 1'b1) begin errors++; $display("FAIL no_stall_op8 got=%b exp=1", pc_we); end
      @(posedge clk); #1;
      checks++; if ({id_valid, id_opcode} !== {1'b1, 4'd8}) begin
         errors++; $display("FAIL no_stall_issue got v=%b op=%0d exp v=1 op=8", id_valid, id_opcode);
      end
      @(negedge clk); ex_mem_read = 0; ex_rd = 0;
   endtask

   task automatic test_flush_stall();
      @(negedge clk); instr_if = 16'h1A83; pc_next_if = 16'h0060;
      @(negedge clk); ex_mem_read = 1; ex_rd = 2; flush = 1;
      #1;
      checks++; if (pc_we !== 1'b1) begin errors++; $display("FAIL flush_pc_we got=%b exp=1", pc_we); end
      @(posedge clk); #1;
      checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL flush_bubble got=%b exp=0", id_valid); end
      @(negedge clk); flush = 0; ex_mem_read = 0; ex_rd = 0;
      @(posedge clk); #1;
      checks++; if (dut_vec !== 75'd0) begin errors++; $display("FAIL flush_nop got=%h exp=0", dut_vec); end
   endtask

   task automatic test_bypass();
      @(negedge clk); instr_if = 16'h1300;
      @(negedge clk); instr_if = 16'h0000; wb_we = 1; wb_addr = 4; wb_data = 16'hBEEF;
      @(posedge clk); #1;
      checks++; if (id_rs_data !== 16'hBEEF) begin errors++; $display("FAIL bypass got=%h exp=BEEF", id_rs_data); end
      @(negedge clk); wb_addr = 0; wb_data = 16'h1234;
      @(posedge clk); #1;
      checks++; if (id_rs_data !== 16'h0000) begin errors++; $display("FAIL r0_read got=%h exp=0", id_rs_data); end
      @(negedge clk); wb_we = 0;
      @(posedge clk); #1;
      checks++; if (dut_vec !== e_vec) begin errors++; $display("FAIL r0_model got=%h exp=%h", dut_vec, e_vec); end
   endtask

   task automatic test_reset_mid_stall();
      @(negedge clk); instr_if = 16'h0299; pc_next_if = 16'h0070;
      @(negedge clk); ex_mem_read = 1; ex_rd = 3;
      #2; rst = 1'b1; #1;
      checks++; if ({pc_we, dut_vec} !== {1'b1, 75'd0}) begin
         errors++; $display("FAIL reset_mid_stall got pc_we=%b vec=%h exp pc_we=1 vec=0", pc_we, dut_vec);
      end
      idle_inputs();
      @(negedge clk); rst = 1'b0; instr_if = 16'h0299; pc_next_if = 16'h0071;
      @(negedge clk); instr_if = 16'h8000;
      @(posedge clk); #1;
      checks++; if ({id_valid, id_rs_data, id_rt_data} !== {1'b1, 32'd0}) begin
         errors++; $display("FAIL regs_cleared got v=%b rs=%h rt=%h exp v=1 rs=0 rt=0", id_valid, id_rs_data, id_rt_data);
      end
   endtask

   task automatic test_random();
      logic prev_stall;
      prev_stall = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         instr_if    = 16'($urandom);
         instr_if[15] = ($urandom_range(0, 3) == 0);
         pc_next_if  = 16'($urandom);
         flush       = ($urandom_range(0, 9) == 0);
         ex_mem_read = prev_stall ? 1'b0 : ($urandom_range(0, 1) == 0);
         ex_rd       = 3'($urandom);
         wb_we       = 1'($urandom);
         wb_addr     = 3'($urandom);
         wb_data     = 16'($urandom);
         #1;
         checks++; if (pc_we !== exp_pc_we) begin errors++; $display("FAIL rand_pc_we cyc=%0d got=%b exp=%b", i, pc_we, exp_pc_we); end
         prev_stall = m_stall;
         @(posedge clk); #1;
         checks++; if (dut_vec !== e_vec) begin errors++; $display("FAIL rand_id cyc=%0d got=%h exp=%h", i, dut_vec, e_vec); end
      end
      @(negedge clk); idle_inputs();
   endtask

   initial begin
      test_reset();
      test_rtype();
      test_imm();
      test_stall();
      test_no_stall();
      test_flush_stall();
      test_bypass();
      test_reset_mid_stall();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
